// File: rtl/reset_sequencer.sv
// reset_sequencer -- multi-source reset generator for the core clock domain.
//
// Synchronises and edge-detects NUM_SRC trigger sources, holds every domain
// in reset for HOLD_CYCLES locked cycles after the last trigger, then
// releases NUM_DOMAINS resets one at a time, STAGE_GAP cycles apart
// (bit 0 first). A synced falling edge of pll_locked also restarts the hold.
// A sticky record of which sources fired is kept in cause.
//
// Optional feature: define RESET_SEQ_STICKY_EN to add the STICKY state
// (entered by sticky_set, left only by a trigger on source 0).
//
// Ports:
//   clk         sequencer clock
//   reset_n     asynchronous active-low reset
//   src_in      raw asynchronous trigger sources
//   src_mask    per-source enable (synchronous to clk)
//   pll_locked  PLL lock, synchronised internally
//   cause_clr   clears the cause register
//   sticky_set  enter sticky hold (only with RESET_SEQ_STICKY_EN)
//   rst_out     active-high domain resets, bit 0 released first
//   busy        high while any rst_out bit is asserted
//   cause       sticky record of sources that triggered
module reset_sequencer #(
  parameter int                 NUM_SRC     = 4,
  parameter int                 NUM_DOMAINS = 3,
  parameter int                 HOLD_CYCLES = 16,
  parameter int                 STAGE_GAP   = 4,
  parameter logic [NUM_SRC-1:0] SRC_EDGE    = {NUM_SRC{1'b1}},
  parameter int                 SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SRC-1:0]     src_in,
  input  logic [NUM_SRC-1:0]     src_mask,
  input  logic                   pll_locked,
  input  logic                   cause_clr,
  input  logic                   sticky_set,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   busy,
  output logic [NUM_SRC-1:0]     cause
);

  // A limit of 1 would give a zero-width counter; keep at least one bit.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_STICKY  = 2'd3
  } state_t;

  state_t                                state;
  logic [HW-1:0]                         hold_cnt;
  logic [SW-1:0]                         stage_cnt;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   src_sync;
  logic [NUM_SRC-1:0]                    src_hist;
  logic [SYNC_STAGES-1:0]                lock_sync;
  logic                                  lock_hist;

  logic [NUM_SRC-1:0]                    src_s;
  logic [NUM_SRC-1:0]                    trig;
  logic                                  lock_s;
  logic                                  lock_fall;
  logic                                  restart;
  logic [NUM_DOMAINS-1:0]                rst_shift;

  // Synchroniser chains plus one history flop each for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_sync  <= '0;
      src_hist  <= '0;
      lock_sync <= '0;
      lock_hist <= 1'b0;
    end else begin
      src_sync[0]  <= src_in;
      lock_sync[0] <= pll_locked;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        src_sync[s]  <= src_sync[s-1];
        lock_sync[s] <= lock_sync[s-1];
      end
      src_hist  <= src_sync[SYNC_STAGES-1];
      lock_hist <= lock_sync[SYNC_STAGES-1];
    end
  end

  assign src_s     = src_sync[SYNC_STAGES-1];
  assign trig      = ((SRC_EDGE & src_s & ~src_hist) |
                      (~SRC_EDGE & ~src_s & src_hist)) & src_mask;
  assign lock_s    = lock_sync[SYNC_STAGES-1];
  // Lock history resets to 0, so coming out of reset never looks like a loss.
  assign lock_fall = lock_hist & ~lock_s;
  assign restart   = (|trig) | lock_fall;

  // Domains release bottom-up: shifting zeros in from bit 0 keeps the
  // release order monotonic by construction.
  assign rst_shift = rst_out << 1;

`ifndef RESET_SEQ_STICKY_EN
  logic unused_sticky;
  assign unused_sticky = sticky_set;
`endif

  // A new trigger survives a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cause <= '0;
    else          cause <= (cause_clr ? '0 : cause) | trig;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      stage_cnt <= '0;
      rst_out   <= '1;
      busy      <= 1'b1;
    end else begin
`ifdef RESET_SEQ_STICKY_EN
      if (sticky_set) begin
        state     <= S_STICKY;
        hold_cnt  <= '0;
        stage_cnt <= '0;
        rst_out   <= '1;
        busy      <= 1'b1;
      end else if (state == S_STICKY) begin
        // Only source 0 leaves; other triggers and lock loss are ignored.
        if (trig[0]) state <= S_HOLD;
      end else
`endif
      if (restart) begin
        state     <= S_HOLD;
        hold_cnt  <= '0;
        stage_cnt <= '0;
        rst_out   <= '1;
        busy      <= 1'b1;
      end else begin
        case (state)
          S_HOLD: begin
            if (!lock_s) begin
              hold_cnt <= '0;
            end else if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
              // Counter stays at its terminal value; release domain 0 now.
              stage_cnt <= '0;
              rst_out   <= rst_shift;
              busy      <= |rst_shift;
              state     <= (|rst_shift) ? S_RELEASE : S_RUN;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          S_RELEASE: begin
            if (stage_cnt == SW'(STAGE_GAP - 1)) begin
              stage_cnt <= '0;
              rst_out   <= rst_shift;
              busy      <= |rst_shift;
              if (!(|rst_shift)) state <= S_RUN;
            end else begin
              stage_cnt <= stage_cnt + SW'(1);
            end
          end
          S_RUN: begin
            rst_out <= '0;
            busy    <= 1'b0;
          end
          default: begin
            state    <= S_HOLD;
            hold_cnt <= '0;
            rst_out  <= '1;
            busy     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters.
// Inputs change 1ns after a rising edge; outputs are sampled at that point,
// so "edge N" below means the Nth rising edge since the step began.
module tb_reset_sequencer;

  logic       clk;
  logic       reset_n;
  logic [3:0] src_in;
  logic [3:0] src_mask;
  logic       pll_locked;
  logic       cause_clr;
  logic       sticky_set;
  logic [2:0] rst_out;
  logic       busy;
  logic [3:0] cause;

  int checks = 0;
  int errors = 0;

  reset_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .src_in     (src_in),
    .src_mask   (src_mask),
    .pll_locked (pll_locked),
    .cause_clr  (cause_clr),
    .sticky_set (sticky_set),
    .rst_out    (rst_out),
    .busy       (busy),
    .cause      (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    src_in     = 4'b0000;
    src_mask   = 4'b1111;
    pll_locked = 1'b1;
    cause_clr  = 1'b0;
    sticky_set = 1'b0;
    tick(3);
    chk("reset_rst", 32'(rst_out), 32'h7);
    chk("reset_busy", 32'(busy), 32'h1);
    chk("reset_cause", 32'(cause), 32'h0);

    // 1: power-up. Synced lock arrives at edge 2, release 16 edges later.
    reset_n = 1'b1;
    tick(17);
    chk("t1_hold_end", 32'(rst_out), 32'h7);
    tick(1);
    chk("t1_rel0", 32'(rst_out), 32'h6);
    chk("t1_busy_rel", 32'(busy), 32'h1);
    tick(3);
    chk("t1_gap0", 32'(rst_out), 32'h6);
    tick(1);
    chk("t1_rel1", 32'(rst_out), 32'h4);
    tick(3);
    chk("t1_gap1", 32'(rst_out), 32'h4);
    tick(1);
    chk("t1_rel2", 32'(rst_out), 32'h0);
    chk("t1_busy0", 32'(busy), 32'h0);
    chk("t1_cause", 32'(cause), 32'h0);

    // 2: src 1 rising in RUN -> reset exactly 3 edges later.
    src_in[1] = 1'b1;
    tick(2);
    chk("t2_latency_early", 32'(rst_out), 32'h0);
    tick(1);
    chk("t2_assert", 32'(rst_out), 32'h7);
    chk("t2_cause", 32'(cause), 32'h2);
    tick(15);
    chk("t2_hold_end", 32'(rst_out), 32'h7);
    tick(1);
    chk("t2_rel0", 32'(rst_out), 32'h6);
    tick(4);
    chk("t2_rel1", 32'(rst_out), 32'h4);
    tick(4);
    chk("t2_rel2", 32'(rst_out), 32'h0);
    chk("t2_busy0", 32'(busy), 32'h0);

    // 3: masked source toggling has no effect.
    src_mask[2] = 1'b0;
    repeat (4) begin
      src_in[2] = ~src_in[2];
      tick(2);
    end
    tick(4);
    chk("t3_masked_rst", 32'(rst_out), 32'h0);
    chk("t3_masked_cause", 32'(cause), 32'h2);
    src_mask[2] = 1'b1;

    // 4: falling edge of a rising-polarity source is ignored; then retrigger
    // via src 1 and interrupt RELEASE with a src 0 pulse.
    src_in[1] = 1'b0;
    tick(4);
    chk("t4_fall_ignored", 32'(rst_out), 32'h0);
    src_in[1] = 1'b1;
    tick(3);
    chk("t4_assert", 32'(rst_out), 32'h7);
    tick(16);
    chk("t4_rel0", 32'(rst_out), 32'h6);
    src_in[0] = 1'b1;
    tick(1);
    src_in[0] = 1'b0;
    tick(1);
    chk("t4_still_rel", 32'(rst_out), 32'h6);
    tick(1);
    chk("t4_reassert", 32'(rst_out), 32'h7);
    chk("t4_cause", 32'(cause), 32'h3);
    tick(15);
    chk("t4_hold_end", 32'(rst_out), 32'h7);
    tick(1);
    chk("t4_rel0_again", 32'(rst_out), 32'h6);
    tick(8);
    chk("t4_run", 32'(rst_out), 32'h0);

    // 5: lock loss in HOLD restarts and freezes the count.
    src_in[0] = 1'b1;
    tick(1);
    src_in[0] = 1'b0;
    tick(2);
    chk("t5_assert", 32'(rst_out), 32'h7);
    tick(5);
    pll_locked = 1'b0;
    tick(10);
    chk("t5_unlocked", 32'(rst_out), 32'h7);
    pll_locked = 1'b1;
    tick(17);
    chk("t5_hold_end", 32'(rst_out), 32'h7);
    tick(1);
    chk("t5_rel0", 32'(rst_out), 32'h6);
    chk("t5_cause", 32'(cause), 32'h3);
    tick(8);
    chk("t5_run", 32'(rst_out), 32'h0);

    // 6: clear coinciding with a src 3 trigger keeps only the new bit.
    src_in[3] = 1'b1;
    tick(2);
    cause_clr = 1'b1;
    tick(1);
    cause_clr = 1'b0;
    chk("t6_cause", 32'(cause), 32'h8);
    chk("t6_assert", 32'(rst_out), 32'h7);
    tick(16);
    chk("t6_rel0", 32'(rst_out), 32'h6);
    tick(8);
    chk("t6_run", 32'(rst_out), 32'h0);

`ifdef RESET_SEQ_STICKY_EN
    sticky_set = 1'b1;
    tick(1);
    sticky_set = 1'b0;
    chk("sticky_enter", 32'(rst_out), 32'h7);
    chk("sticky_busy", 32'(busy), 32'h1);
    src_in[3] = 1'b0;
    tick(3);
    src_in[3] = 1'b1;
    tick(23);
    chk("sticky_src3_ignored", 32'(rst_out), 32'h7);
    chk("sticky_cause", 32'(cause), 32'h8);
    src_in[0] = 1'b1;
    tick(1);
    src_in[0] = 1'b0;
    tick(2);
    chk("sticky_exit", 32'(rst_out), 32'h7);
    tick(16);
    chk("sticky_rel0", 32'(rst_out), 32'h6);
    tick(8);
    chk("sticky_run", 32'(rst_out), 32'h0);
    chk("sticky_cause_after", 32'(cause), 32'h9);
`else
    sticky_set = 1'b1;
    tick(1);
    sticky_set = 1'b0;
    chk("nosticky_rst", 32'(rst_out), 32'h0);
    chk("nosticky_busy", 32'(busy), 32'h0);
    tick(3);
    chk("nosticky_later", 32'(rst_out), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
